lif_param_serializer: RTL and testbench

Serial parameter transmitter for the LIF neuron's configuration loader. It snapshots a full parameter set (weight, leak rate, threshold, leak cycles) on a start request and shifts it out MSB-first on `load_mode`/`serial_data`. It then waits for the loader's `params_ready` acknowledge and reports completion or timeout. It sits upstream of the single-neuron system, driving its `load_mode` and `serial_data` inputs from a host or register interface.

---
 rtl/lif_param_serializer.sv | 134 +++++++++++++
 tb/tb_lif_param_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lif_param_serializer.sv
// Serial parameter transmitter for the LIF neuron configuration loader.
// Snapshots {weight, leak_rate, threshold, leak_cycles} and shifts it out MSB-first, then waits for ack.
//
// state    | meaning
// IDLE     | waiting for start; outputs quiet, error holds its last value
// SHIFT    | load_mode=1, driving shift_reg[22] for BIT_CYCLES cycles per bit
// WAIT_ACK | frame sent, counting cycles until params_ready or timeout
// DONE     | one enabled cycle of done, then back to IDLE
module lif_param_serializer #(
  parameter int BIT_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_start,
  input  logic [2:0] i_weight_in,
  input  logic [7:0] i_leak_rate_in,
  input  logic [7:0] i_threshold_in,
  input  logic [3:0] i_leak_cycles_in,
  input  logic       i_params_ready,
  output logic       o_load_mode,
  output logic       o_serial_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int HW = $clog2(BIT_CYCLES) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHIFT    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [22:0]     r_shift;
  logic [4:0]      r_bit_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_error;

  logic            w_hold_last;
  logic            w_last_bit;
  logic            w_timeout;

  assign w_hold_last = (r_hold_cnt == HOLD_LAST);
  assign w_last_bit  = w_hold_last && (r_bit_cnt == 5'd0);
  assign w_timeout   = (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else if (i_enable) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next_state = S_SHIFT;
      S_SHIFT:    if (w_last_bit) w_next_state = S_WAIT_ACK;
      // ready is checked before the timeout so a same-cycle ack is never flagged as an error
      S_WAIT_ACK: if (i_params_ready || w_timeout) w_next_state = S_DONE;
      S_DONE:     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_hold_cnt <= '0;
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shift    <= {i_weight_in, i_leak_rate_in, i_threshold_in, i_leak_cycles_in};
            r_bit_cnt  <= 5'd22;
            r_hold_cnt <= '0;
            r_wait_cnt <= '0;
            r_error    <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_hold_last) begin
            r_hold_cnt <= '0;
            if (r_bit_cnt != 5'd0) begin
              r_shift   <= {r_shift[21:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (!i_params_ready) begin
            if (w_timeout) begin
              r_error <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + WW'(1);
            end
          end
        end
        S_DONE: begin
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally
  always_comb begin
    o_load_mode   = 1'b0;
    o_serial_data = 1'b0;
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_DONE);
    o_error       = r_error;
    if (r_state == S_SHIFT) begin
      o_load_mode   = 1'b1;
      o_serial_data = r_shift[22];
    end
  end

endmodule

// File: tb/tb_lif_param_serializer.sv
// Bench for lif_param_serializer: table of frames plus reset, stall, busy-start and bit-stretch sequences.
// Expected serial bits are queued at start and consumed as the selected DUT drives load_mode.
module tb_lif_param_serializer;

  localparam int TO = 4;

  typedef struct {
    logic [2:0]  w;
    logic [7:0]  lr;
    logic [7:0]  th;
    logic [3:0]  lc;
    logic [22:0] frame;
    int          delay;
    logic        err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, enable, start, ready;
  logic [2:0] w;
  logic [7:0] lr, th;
  logic [3:0] lc;
  logic       lm1, sd1, bz1, dn1, er1;
  logic       lm3, sd3, bz3, dn3, er3;
  logic       lm, sd, bz, dn, er;
  logic       sel;

  int   n_vec = 0;
  int   n_fail = 0;
  logic prev_err;
  logic q[$];
  vec_t vt[4];

  always #5 clk = ~clk;

  lif_param_serializer #(.BIT_CYCLES(1), .TIMEOUT(TO)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start),
    .i_weight_in(w), .i_leak_rate_in(lr), .i_threshold_in(th), .i_leak_cycles_in(lc),
    .i_params_ready(ready), .o_load_mode(lm1), .o_serial_data(sd1), .o_busy(bz1),
    .o_done(dn1), .o_error(er1));

  lif_param_serializer #(.BIT_CYCLES(3), .TIMEOUT(TO)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start),
    .i_weight_in(w), .i_leak_rate_in(lr), .i_threshold_in(th), .i_leak_cycles_in(lc),
    .i_params_ready(ready), .o_load_mode(lm3), .o_serial_data(sd3), .o_busy(bz3),
    .o_done(dn3), .o_error(er3));

  always_comb begin
    lm = sel ? lm3 : lm1;
    sd = sel ? sd3 : sd1;
    bz = sel ? bz3 : bz1;
    dn = sel ? dn3 : dn1;
    er = sel ? er3 : er1;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic run_frame(input int vi, input int bc, input int stall_e, input int stall_n,
                           input bit mid_start);
    int   ws, dc, e, stalled, guard, nv;
    logic xerr;
    sel  = (bc == 3);
    ws   = 23 * bc + 1;
    dc   = ws + ((vt[vi].delay < TO) ? vt[vi].delay : TO - 1) + 1;
    xerr = vt[vi].err;
    nv   = (vi + 1) % 4;
    chk("idle_busy", bz, 1'b0);
    chk("idle_load_mode", lm, 1'b0);
    chk("idle_done", dn, 1'b0);
    chk("idle_error_sticky", er, prev_err);
    q.delete();
    for (int b = 22; b >= 0; b--)
      for (int r = 0; r < bc; r++) q.push_back(vt[vi].frame[b]);
    w = vt[vi].w; lr = vt[vi].lr; th = vt[vi].th; lc = vt[vi].lc;
    start = 1'b1; enable = 1'b1; ready = (vt[vi].delay == 0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    w = ~vt[vi].w; lr = ~vt[vi].lr; th = ~vt[vi].th; lc = ~vt[vi].lc;
    e = 1; stalled = 0; guard = 0;
    while (e <= dc + 1 && guard < 500) begin
      guard++;
      chk("load_mode", lm, (e <= 23 * bc));
      chk("busy", bz, (e <= dc));
      chk("done", dn, (e == dc));
      chk("error", er, (e < dc) ? 1'b0 : xerr);
      if (lm) begin
        if (q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL serial_extra_bit at %0t: got load_mode=1, expected no more bits", $time);
        end else chk("serial_data", sd, q[0]);
      end else chk("serial_idle", sd, 1'b0);
      ready = (vt[vi].delay == 0) || (e >= ws + vt[vi].delay);
      if (mid_start && e == 8) begin
        start = 1'b1;
        w = vt[nv].w; lr = vt[nv].lr; th = vt[nv].th; lc = vt[nv].lc;
      end else start = 1'b0;
      if (e == stall_e && stalled < stall_n) begin
        enable = 1'b0;
        stalled++;
      end else begin
        enable = 1'b1;
        if (lm && q.size() > 0) void'(q.pop_front());
        e++;
      end
      if (e <= dc + 1) begin
        @(posedge clk); @(negedge clk);
      end
    end
    if (guard >= 500) begin
      n_vec++; n_fail++;
      $display("FAIL frame_budget at %0t: got no completion, expected done by cycle %0d", $time, dc);
    end
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_length at %0t: got %0d bits unsent, expected 0", $time, q.size());
    end
    start = 1'b0; enable = 1'b1; ready = 1'b0;
    prev_err = xerr;
  endtask

  task automatic reset_mid_shift();
    sel = 1'b0;
    w = vt[0].w; lr = vt[0].lr; th = vt[0].th; lc = vt[0].lc;
    start = 1'b1; enable = 1'b1; ready = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    chk("pre_reset_load_mode", lm, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_load_mode", lm, 1'b0);
    chk("rst_serial_data", sd, 1'b0);
    chk("rst_busy", bz, 1'b0);
    chk("rst_done", dn, 1'b0);
    chk("rst_error", er, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_busy", bz, 1'b0);
    chk("post_rst_load_mode", lm, 1'b0);
    prev_err = 1'b0;
  endtask

  initial begin
    vt[0] = '{w:3'b101, lr:8'h3C, th:8'hA5, lc:4'h9, frame:23'b101_00111100_10100101_1001, delay:0,  err:1'b0};
    vt[1] = '{w:3'b000, lr:8'hFF, th:8'h00, lc:4'hF, frame:23'b000_11111111_00000000_1111, delay:2,  err:1'b0};
    vt[2] = '{w:3'b111, lr:8'h01, th:8'h80, lc:4'h0, frame:23'b111_00000001_10000000_0000, delay:99, err:1'b1};
    vt[3] = '{w:3'b010, lr:8'h5A, th:8'hC3, lc:4'h6, frame:23'b010_01011010_11000011_0110, delay:3,  err:1'b0};

    sel = 1'b0; rst_n = 1'b0; enable = 1'b1; start = 1'b0; ready = 1'b0;
    w = '0; lr = '0; th = '0; lc = '0; prev_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_error_bc3", er3, 1'b0);
    chk("reset_busy_bc3", bz3, 1'b0);

    for (int i = 0; i < 4; i++) run_frame(i, 1, 0, 0, 1'b0);
    run_frame(0, 1, 0, 0, 1'b1);
    run_frame(1, 1, 13, 5, 1'b0);
    reset_mid_shift();
    run_frame(0, 3, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: got no end of test, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
